// File: rtl/div_issue_ctrl.sv
// Issue/complete controller for a multi-cycle divider feeding HI/LO.
// Optional macro DIV_ZERO_BYPASS_EN: zero divisors complete directly without a divider trip.
//
// state | meaning
// IDLE  | no divide outstanding; accepts a new DIV/DIVU from EX
// ISSUE | one-cycle operand-valid pulse to the divider
// WAIT  | ready for the divider result
// DONE  | result held in hi_o/lo_o until the downstream accepts it
module div_issue_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_en,
  input  logic        div_sign,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        mem_stall,
  output logic        ex_stall,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_rst,
  output logic        div_opn_valid,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_sign_o,
  output logic        div_res_ready,
  input  logic        div_res_valid,
  input  logic [63:0] div_result
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state;
  logic   active;
  logic   zero_bypass;

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_bypass = (src_b == 32'd0);
`else
  assign zero_bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      hi_o       <= 32'd0;
      lo_o       <= 32'd0;
      div_a      <= 32'd0;
      div_b      <= 32'd0;
      div_sign_o <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_en) begin
            div_a      <= src_a;
            div_b      <= src_b;
            div_sign_o <= div_sign;
            if (zero_bypass) begin
              hi_o  <= src_a;
              lo_o  <= 32'hFFFF_FFFF;
              state <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (div_res_valid) begin
            hi_o  <= div_result[63:32];
            lo_o  <= div_result[31:0];
            state <= DONE;
          end
        end
        DONE: begin
          if (!mem_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset and flush both mask every handshake/strobe in the same cycle.
  assign active        = resetn & ~flush;
  assign div_rst       = ~resetn | flush;
  assign ex_stall      = active & (((state == IDLE) & div_en) | (state == ISSUE) | (state == WAIT));
  assign div_opn_valid = active & (state == ISSUE);
  assign div_res_ready = active & (state == WAIT);
  assign hilo_we       = active & (state == DONE) & ~mem_stall;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized + directed bench for div_issue_ctrl against a transaction-level model and a bench-side divider.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn, div_en, div_sign, flush, mem_stall, div_res_valid;
  logic [31:0] src_a, src_b;
  logic [63:0] div_result;
  logic        ex_stall, hilo_we, div_rst, div_opn_valid, div_sign_o, div_res_ready;
  logic [31:0] hi_o, lo_o, div_a, div_b;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk(clk), .resetn(resetn), .div_en(div_en), .div_sign(div_sign),
    .src_a(src_a), .src_b(src_b), .flush(flush), .mem_stall(mem_stall),
    .ex_stall(ex_stall), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o),
    .div_rst(div_rst), .div_opn_valid(div_opn_valid), .div_a(div_a), .div_b(div_b),
    .div_sign_o(div_sign_o), .div_res_ready(div_res_ready),
    .div_res_valid(div_res_valid), .div_result(div_result)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {remainder, quotient}; zero divisor yields {a, all-ones}.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  // Transaction model: an op is held from acceptance until its HI/LO write.
  bit          m_op, m_sent, m_done, m_known;
  logic [31:0] m_a, m_b, m_hi, m_lo;
  logic        m_sign;

  // Bench-side divider.
  bit          d_busy, d_valid;
  int          d_cnt;
  int          lat_override = -1;
  logic [63:0] d_res;

  logic        obs_we, obs_opn, obs_rst, obs_stall;
  logic [31:0] obs_hi, obs_lo;
  logic        cap_opn, cap_ready, cap_s;
  logic [31:0] cap_a, cap_b;

  task automatic cycle(input logic i_rst, input logic i_en, input logic i_sign,
                       input logic [31:0] i_a, input logic [31:0] i_b,
                       input logic i_flush, input logic i_ms);
    bit act, p_idle, p_issue, p_wait, p_done;
    @(negedge clk);
    resetn = i_rst; div_en = i_en; div_sign = i_sign; src_a = i_a; src_b = i_b;
    flush = i_flush; mem_stall = i_ms;
    div_res_valid = d_valid;
    div_result = d_valid ? d_res : {$urandom, $urandom};
    #1;
    act     = i_rst && !i_flush;
    p_idle  = !m_op;
    p_issue = m_op && !m_sent && !m_done;
    p_wait  = m_sent && !m_done;
    p_done  = m_done;
    check("ex_stall", ex_stall, act && ((p_idle && i_en) || p_issue || p_wait));
    check("div_opn_valid", div_opn_valid, act && p_issue);
    check("div_res_ready", div_res_ready, act && p_wait);
    check("hilo_we", hilo_we, act && p_done && !i_ms);
    check("div_rst", div_rst, !i_rst || i_flush);
    if (m_known) begin
      check("hi_o", hi_o, m_hi);
      check("lo_o", lo_o, m_lo);
      check("div_a", div_a, m_a);
      check("div_b", div_b, m_b);
      check("div_sign_o", div_sign_o, m_sign);
    end
    if (div_opn_valid) check("opn_while_outstanding", d_busy || d_valid, 0);
    obs_we = hilo_we; obs_opn = div_opn_valid; obs_rst = div_rst; obs_stall = ex_stall;
    obs_hi = hi_o; obs_lo = lo_o;
    cap_opn = div_opn_valid; cap_ready = div_res_ready;
    cap_a = div_a; cap_b = div_b; cap_s = div_sign_o;
    @(posedge clk);
    if (!i_rst) begin
      m_op = 0; m_sent = 0; m_done = 0; m_known = 1;
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_sign = 0;
    end else if (i_flush) begin
      m_op = 0; m_sent = 0; m_done = 0;
    end else if (p_idle) begin
      if (i_en) begin
        m_a = i_a; m_b = i_b; m_sign = i_sign; m_op = 1;
`ifdef DIV_ZERO_BYPASS_EN
        if (i_b == 32'd0) begin
          m_done = 1; m_hi = i_a; m_lo = 32'hFFFF_FFFF;
        end
`endif
      end
    end else if (p_issue) begin
      m_sent = 1;
    end else if (p_wait) begin
      if (div_res_valid) begin
        {m_hi, m_lo} = div_ref(m_a, m_b, m_sign);
        m_done = 1;
      end
    end else if (p_done && !i_ms) begin
      m_op = 0; m_sent = 0; m_done = 0;
    end
    if (obs_rst) begin
      d_busy = 0; d_valid = 0;
    end else begin
      if (d_valid && cap_ready) d_valid = 0;
      if (cap_opn) begin
        d_busy = 1;
        d_res  = div_ref(cap_a, cap_b, cap_s);
        d_cnt  = (lat_override >= 0) ? lat_override : int'($urandom_range(0, 5));
      end else if (d_busy) begin
        if (d_cnt == 0) begin
          d_busy = 0; d_valid = 1;
        end else begin
          d_cnt--;
        end
      end
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int stall,
                        input logic [31:0] ehi, input logic [31:0] elo, input int eopn,
                        output int ncyc);
    int we_cnt = 0, opn_cnt = 0, left = stall;
    logic ms;
    ncyc = 0;
    while (we_cnt == 0 && ncyc < 100) begin
      ms = m_done && left > 0;
      cycle(1, 1, s, a, b, 0, ms);
      if (ms) begin
        left--;
        check("stalled_no_we", obs_we, 0);
      end
      opn_cnt += obs_opn;
      we_cnt  += obs_we;
      ncyc++;
    end
    check("div_completed", we_cnt, 1);
    check("div_hi", obs_hi, ehi);
    check("div_lo", obs_lo, elo);
    check("ex_stall_at_we", obs_stall, 0);
    check("opn_pulses", opn_cnt, eopn);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nc, k, we_seen;
    logic [31:0] ra, rb;
    d_busy = 0; d_valid = 0; m_known = 0;
    m_op = 0; m_sent = 0; m_done = 0;

    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'd5, 32'd1, 0, 0);
    check("reset_div_rst", obs_rst, 1);
    check("reset_hi", obs_hi, 0);
    check("reset_lo", obs_lo, 0);
    check("reset_opn", obs_opn, 0);

    do_div(32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 1, nc);
    cycle(1, 0, 0, 0, 0, 0, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, nc);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // Flush ten cycles after issue with a slow divider.
    lat_override = 30;
    k = 0; we_seen = 0;
    while (!m_sent && k < 10) begin
      cycle(1, 1, 0, 32'd100, 32'd7, 0, 0);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0, 32'd100, 32'd7, 0, 0);
      we_seen += obs_we;
    end
    cycle(1, 1, 0, 32'd100, 32'd7, 1, 0);
    check("flush_div_rst", obs_rst, 1);
    we_seen += obs_we;
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("after_flush_idle", obs_stall, 0);
    we_seen += obs_we;
    check("flush_no_we", we_seen, 0);
    lat_override = -1;
    do_div(32'd9, 32'd3, 0, 0, 32'd0, 32'd3, 1, nc);
    cycle(1, 0, 0, 0, 0, 0, 0);

    do_div(32'd100, 32'd7, 0, 3, 32'd2, 32'd14, 1, nc);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("single_we_pulse", obs_we, 0);

    do_div(32'd50, 32'd5, 0, 0, 32'd0, 32'd10, 1, nc);
    do_div(32'd17, 32'd4, 0, 0, 32'd1, 32'd4, 1, nc);
    cycle(1, 0, 0, 0, 0, 0, 0);

`ifdef DIV_ZERO_BYPASS_EN
    do_div(32'd123, 32'd0, 0, 0, 32'd123, 32'hFFFF_FFFF, 0, nc);
    check("bypass_latency", nc, 2);
`else
    do_div(32'd123, 32'd0, 0, 0, 32'd123, 32'hFFFF_FFFF, 1, nc);
`endif
    cycle(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 1000);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2, 3: rb = $urandom_range(1, 20);
        4:       rb = 32'hFFFF_FFFF - $urandom_range(0, 5);
        default: rb = $urandom;
      endcase
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
            ra, rb, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
